// File: rtl/gf283_pkg.sv
// Shared constants and types for the GF(2^283) inverter (NIST B-283 field).
package gf283_pkg;

  localparam int unsigned M       = 283;
  localparam int unsigned ITER    = 2 * M;
  localparam int unsigned CNT_W   = $clog2(ITER);
  localparam int unsigned DELTA_W = $clog2(M) + 2;

  // Field element and the one-bit-wider form used for R/S.
  typedef logic [M-1:0] fe_t;
  typedef logic [M:0]   fe_ext_t;

  // f(x) = x^283 + x^12 + x^7 + x^5 + 1
  localparam fe_ext_t F_POLY = (fe_ext_t'(1) << M)  |
                               (fe_ext_t'(1) << 12) |
                               (fe_ext_t'(1) << 7)  |
                               (fe_ext_t'(1) << 5)  |
                               fe_ext_t'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf283_inverter_if.sv
// Operand/result handshake bundle for the GF(2^283) inverter.
interface gf283_inverter_if;

  logic            in_valid;
  logic            in_ready;
  gf283_pkg::fe_t  a;
  logic            out_valid;
  logic            out_ready;
  gf283_pkg::fe_t  y;
  logic            zero_err;
  logic            busy;

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, y, zero_err, busy
  );

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, y, zero_err, busy
  );

endinterface

// File: rtl/gf283_shift_mod.sv
// Combinational x*u mod f (div_i=0) or u/x mod f (div_i=1) for one field element.
module gf283_shift_mod
  import gf283_pkg::*;
(
  input  fe_t  u_i,
  input  logic div_i,
  output fe_t  res_c
);

  fe_t     mulx;
  fe_t     divx;
  fe_ext_t div_acc;

  // Multiply folds the overflow back with the low part of f; divide first
  // cancels the constant term with f (f has a 1 there) so the shift is exact.
  always_comb begin
    mulx    = {u_i[M-2:0], 1'b0} ^ (u_i[M-1] ? F_POLY[M-1:0] : '0);
    div_acc = {1'b0, u_i} ^ (u_i[0] ? F_POLY : '0);
    divx    = fe_t'(div_acc >> 1);
    res_c   = div_i ? divx : mulx;
  end

endmodule

// File: rtl/gf283_inverter.sv
// Fixed-latency GF(2^283) inverter: one binary extended-Euclid step per clock.
module gf283_inverter
  import gf283_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  gf283_inverter_if.slave    bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DELTA_W-1:0]   delta_q, delta_d;
  fe_ext_t              r_q, r_d;
  fe_ext_t              s_q, s_d;
  fe_t                  u_q, u_d;
  fe_t                  v_q, v_d;
  logic                 zero_q, zero_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 zero_err_q, zero_err_d;
  fe_t                  y_q, y_d;

  logic                 r_m;
  logic                 s_m;
  fe_ext_t              s_x;
  fe_ext_t              s_sh;
  fe_t                  v_x;
  fe_t                  u_step_c;
  fe_t                  v_mulx_c;

  // Conditional S/V reduction against R/U, then S shifted up.
  assign r_m  = r_q[M];
  assign s_m  = s_q[M];
  assign s_x  = s_m ? (s_q ^ r_q) : s_q;
  assign s_sh = {s_x[M-1:0], 1'b0};
  assign v_x  = s_m ? (v_q ^ u_q) : v_q;

  // U is multiplied by x when R lacks its top term, otherwise divided by x.
  gf283_shift_mod u_step (
    .u_i   (u_q),
    .div_i (r_m),
    .res_c (u_step_c)
  );

  // After a swap the new U is the reduced V, multiplied by x.
  gf283_shift_mod v_step (
    .u_i   (v_x),
    .div_i (1'b0),
    .res_c (v_mulx_c)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      delta_q     <= '0;
      r_q         <= '0;
      s_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      zero_err_q  <= 1'b0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delta_q     <= delta_d;
      r_q         <= r_d;
      s_q         <= s_d;
      u_q         <= u_d;
      v_q         <= v_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      zero_err_q  <= zero_err_d;
      y_q         <= y_d;
    end
  end

  // Next-state, iteration step and output next values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delta_d     = delta_q;
    r_d         = r_q;
    s_d         = s_q;
    u_d         = u_q;
    v_d         = v_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    zero_err_d  = zero_err_q;
    y_d         = y_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          r_d        = {1'b0, bus.a};
          s_d        = F_POLY;
          u_d        = fe_t'(1);
          v_d        = '0;
          delta_d    = '0;
          cnt_d      = '0;
          zero_d     = (bus.a == '0);
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_RUN: begin
        if (!r_m) begin
          r_d     = {r_q[M-1:0], 1'b0};
          u_d     = u_step_c;
          delta_d = delta_q + DELTA_W'(1);
        end else if (delta_q == '0) begin
          r_d     = s_sh;
          s_d     = r_q;
          u_d     = v_mulx_c;
          v_d     = u_q;
          delta_d = DELTA_W'(1);
        end else begin
          s_d     = s_sh;
          v_d     = v_x;
          u_d     = u_step_c;
          delta_d = delta_q - DELTA_W'(1);
        end

        if (cnt_q == CNT_W'(ITER - 1)) begin
          cnt_d       = '0;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          y_d         = zero_q ? '0 : u_d;
          zero_err_d  = zero_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero_err  = zero_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gf283_inverter.sv
// Scoreboard bench for gf283_inverter: results checked by field multiplication.
module tb_gf283_inverter;
  import gf283_pkg::*;

  localparam int unsigned PW      = 2 * M - 1;
  localparam int unsigned LAT     = 2 * M + 1;
  localparam int unsigned PERIOD  = LAT + 1;
  localparam int unsigned N_RAND  = 100;

  typedef struct {
    fe_t    a;
    bit     has_exact;
    fe_t    exp_y;
    longint in_edge;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  longint cyc = 0;

  gf283_inverter_if bus ();

  gf283_inverter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t   q[$];
  int     n_chk = 0;
  int     n_pass = 0;
  int     n_sent = 0;
  int     n_results = 0;
  longint last_in_edge = 0;
  bit     b2b_mode = 1'b0;
  longint prev_fv = -1;

  bit     first_seen = 1'b0;
  bit     pend_rdy = 1'b0;
  int     stab_err = 0;
  int     busy_err = 0;
  fe_t    hold_y;
  logic   hold_z;
  fe_t    x_inv;

  task automatic chk(input string name, input fe_t act, input fe_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Polynomial product then long-division reduction by f.
  function automatic fe_t gf_mul(input fe_t x, input fe_t b);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(M); i++)
      if (b[i]) p = p ^ (PW'(x) << i);
    for (int i = int'(PW) - 1; i >= int'(M); i--)
      if (p[i]) p = p ^ (PW'(F_POLY) << (i - int'(M)));
    return p[M-1:0];
  endfunction

  function automatic fe_t rand_fe();
    fe_t v;
    v = '0;
    for (int i = 0; i < 9; i++) v = (v << 32) | fe_t'($urandom());
    if (v == '0) v = fe_t'(1);
    return v;
  endfunction

  task automatic send(input fe_t v, input bit has_exact, input fe_t ey);
    txn_t t;
    int   n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = v;
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", fe_t'(bus.in_ready), fe_t'(1));
      bus.in_valid = 1'b0;
      return;
    end
    t.a = v; t.has_exact = has_exact; t.exp_y = ey; t.in_edge = cyc + 1;
    last_in_edge = t.in_edge;
    q.push_back(t);
    n_sent++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, fe_t'(q.size()), fe_t'(0));
  endtask

  // Monitor: latency, hold stability, busy/in_ready and result correctness.
  always @(negedge clk) begin
    txn_t t;
    bit   inflight;
    if (!rst_n) begin
      first_seen = 1'b0;
      pend_rdy   = 1'b0;
      stab_err   = 0;
      busy_err   = 0;
    end else begin
      if (pend_rdy) begin
        chk("in_ready_after_out", fe_t'(bus.in_ready), fe_t'(1));
        pend_rdy = 1'b0;
      end
      inflight = (q.size() > 0) && (cyc >= q[0].in_edge);
      if (inflight) begin
        if (bus.in_ready || !bus.busy) busy_err++;
        if (first_seen) begin
          if (!bus.out_valid || bus.y !== hold_y || bus.zero_err !== hold_z) stab_err++;
        end else if (bus.out_valid) begin
          first_seen = 1'b1;
          hold_y = bus.y;
          hold_z = bus.zero_err;
          chk("latency", fe_t'(cyc + 1 - q[0].in_edge), fe_t'(LAT));
          if (b2b_mode && prev_fv >= 0)
            chk("interval", fe_t'(cyc + 1 - prev_fv), fe_t'(PERIOD));
          prev_fv = cyc + 1;
        end
        if (bus.out_valid && bus.out_ready) begin
          t = q.pop_front();
          n_results++;
          if (t.a == '0) begin
            chk("zero_err_set", fe_t'(bus.zero_err), fe_t'(1));
            chk("y_zero", bus.y, '0);
          end else begin
            chk("zero_err_clr", fe_t'(bus.zero_err), fe_t'(0));
            chk("a_times_y", gf_mul(t.a, bus.y), fe_t'(1));
          end
          if (t.has_exact) chk("y_exact", bus.y, t.exp_y);
          chk("hold_stable", fe_t'(stab_err), fe_t'(0));
          chk("busy_no_ready", fe_t'(busy_err), fe_t'(0));
          first_seen = 1'b0;
          pend_rdy   = 1'b1;
          stab_err   = 0;
          busy_err   = 0;
        end
      end else if (bus.out_valid) begin
        chk("spurious_out_valid", fe_t'(bus.out_valid), fe_t'(0));
      end
    end
  end

  initial begin
    int n;
    x_inv = (fe_t'(1) << 282) | (fe_t'(1) << 11) | (fe_t'(1) << 6) | (fe_t'(1) << 4);
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", fe_t'(bus.in_ready), fe_t'(1));
    chk("rst_out_valid", fe_t'(bus.out_valid), fe_t'(0));
    chk("rst_y", bus.y, '0);
    chk("rst_zero_err", fe_t'(bus.zero_err), fe_t'(0));
    chk("rst_busy", fe_t'(bus.busy), fe_t'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed operands with known inverses.
    send(fe_t'(1), 1'b1, fe_t'(1));  wait_drain("drain_one");
    send(fe_t'(2), 1'b1, x_inv);     wait_drain("drain_x");
    send(x_inv, 1'b1, fe_t'(2));     wait_drain("drain_xinv");
    send('0, 1'b1, '0);              wait_drain("drain_zero");

    // Backpressure with ignored operand pulses while the result is held.
    bus.out_ready = 1'b0;
    send(rand_fe(), 1'b0, '0);
    n = 0;
    while (!bus.out_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", fe_t'(bus.out_valid), fe_t'(1));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = rand_fe();
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("drain_bp");

    // Reset during iteration 100 aborts the operation.
    send(rand_fe(), 1'b0, '0);
    while (cyc < last_in_edge + 100) begin
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", fe_t'(bus.out_valid), fe_t'(0));
    chk("abort_in_ready", fe_t'(bus.in_ready), fe_t'(1));
    chk("abort_busy", fe_t'(bus.busy), fe_t'(0));
    n_sent = n_sent - q.size();
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", fe_t'(bus.in_ready), fe_t'(1));
    send(fe_t'(1), 1'b1, fe_t'(1));
    wait_drain("drain_after_rst");

    // Random nonzero operands, back to back.
    b2b_mode = 1'b1;
    prev_fv  = -1;
    for (int i = 0; i < int'(N_RAND); i++) send(rand_fe(), 1'b0, '0);
    wait_drain("drain_rand");
    b2b_mode = 1'b0;

    chk("result_count", fe_t'(n_results), fe_t'(n_sent));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
